// File: rtl/phv_assembler.sv
// phv_assembler: collects the leading beats of each packet into one header
// vector for the field-extract stage.
//
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_data_valid/i_data/i_sop/i_eop input beat stream
//   o_data_ready                    beat accepted when high with i_data_valid
//   o_phv, o_phv_valid, i_phv_ready assembled vector and its handshake
//   o_phv_beats                     beats captured into o_phv (1..BEATS)
//   o_pkt_beats                     total packet beats, saturating at 16'hFFFF
//   o_abort_cnt                     packets cut short by a new sop, saturating
module phv_assembler #(
  parameter int unsigned PHV_WIDTH  = 1024,
  parameter int unsigned BEAT_WIDTH = 128,
  parameter int unsigned BEATS      = PHV_WIDTH / BEAT_WIDTH,
  parameter int unsigned BCNT_WIDTH = $clog2(BEATS + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_data_valid,
  input  logic [BEAT_WIDTH-1:0] i_data,
  input  logic                  i_sop,
  input  logic                  i_eop,
  output logic                  o_data_ready,
  output logic [PHV_WIDTH-1:0]  o_phv,
  output logic                  o_phv_valid,
  input  logic                  i_phv_ready,
  output logic [BCNT_WIDTH-1:0] o_phv_beats,
  output logic [15:0]           o_pkt_beats,
  output logic [7:0]            o_abort_cnt
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, OUT} state_e;

  state_e                 state_q, state_d;
  logic [PHV_WIDTH-1:0]   phv_q, phv_d;
  logic [15:0]            pkt_beats_q, pkt_beats_d;
  logic [7:0]             abort_cnt_q, abort_cnt_d;
  logic                   accept;

  always_comb begin
    state_d     = state_q;
    phv_d       = phv_q;
    pkt_beats_d = pkt_beats_q;
    abort_cnt_d = abort_cnt_q;
    accept      = i_data_valid && (state_q != OUT);

    case (state_q)
      IDLE: ; // only an sop beat matters here, handled below
      FILL: begin
        if (accept && !i_sop) begin
          // pkt_beats_q is the next free slot while filling
          for (int unsigned k = 0; k < BEATS; k++) begin
            if (pkt_beats_q == 16'(k)) begin
              phv_d[k*BEAT_WIDTH +: BEAT_WIDTH] = i_data;
            end
          end
          pkt_beats_d = pkt_beats_q + 16'd1;
          if (i_eop) begin
            state_d = OUT;
          end else if (pkt_beats_q == 16'(BEATS - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (accept && !i_sop) begin
          if (pkt_beats_q != 16'hFFFF) begin
            pkt_beats_d = pkt_beats_q + 16'd1;
          end
          if (i_eop) begin
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (i_phv_ready) begin
          state_d     = IDLE;
          phv_d       = '0;
          pkt_beats_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // An sop beat always restarts capture; outside IDLE it also abandons the
    // packet in progress (OUT never accepts, so only FILL/DRAIN reach here).
    if (accept && i_sop) begin
      if (state_q != IDLE && abort_cnt_q != 8'hFF) begin
        abort_cnt_d = abort_cnt_q + 8'd1;
      end
      phv_d                 = '0;
      phv_d[BEAT_WIDTH-1:0] = i_data;
      pkt_beats_d           = 16'd1;
      if (i_eop) begin
        state_d = OUT;
      end else if (BEATS == 1) begin
        state_d = DRAIN;
      end else begin
        state_d = FILL;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      phv_q       <= '0;
      pkt_beats_q <= '0;
      abort_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      phv_q       <= phv_d;
      pkt_beats_q <= pkt_beats_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign o_data_ready = (state_q != OUT);
  assign o_phv_valid  = (state_q == OUT);
  assign o_phv        = phv_q;
  assign o_pkt_beats  = pkt_beats_q;
  assign o_abort_cnt  = abort_cnt_q;
  assign o_phv_beats  = (pkt_beats_q >= 16'(BEATS)) ? BCNT_WIDTH'(BEATS)
                                                    : BCNT_WIDTH'(pkt_beats_q);

endmodule

// File: tb/tb_phv_assembler.sv
// Testbench for phv_assembler: randomized and directed packet streams checked
// every cycle against a queue-based packet model.
module tb_phv_assembler;

  localparam int unsigned PHV_WIDTH  = 1024;
  localparam int unsigned BEAT_WIDTH = 128;
  localparam int unsigned BEATS      = PHV_WIDTH / BEAT_WIDTH;
  localparam int unsigned BCNT_WIDTH = $clog2(BEATS + 1);

  logic                  i_clk;
  logic                  i_rst_n;
  logic                  i_data_valid;
  logic [BEAT_WIDTH-1:0] i_data;
  logic                  i_sop;
  logic                  i_eop;
  logic                  o_data_ready;
  logic [PHV_WIDTH-1:0]  o_phv;
  logic                  o_phv_valid;
  logic                  i_phv_ready;
  logic [BCNT_WIDTH-1:0] o_phv_beats;
  logic [15:0]           o_pkt_beats;
  logic [7:0]            o_abort_cnt;

  phv_assembler #(
    .PHV_WIDTH (PHV_WIDTH),
    .BEAT_WIDTH(BEAT_WIDTH)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_data_valid(i_data_valid),
    .i_data      (i_data),
    .i_sop       (i_sop),
    .i_eop       (i_eop),
    .o_data_ready(o_data_ready),
    .o_phv       (o_phv),
    .o_phv_valid (o_phv_valid),
    .i_phv_ready (i_phv_ready),
    .o_phv_beats (o_phv_beats),
    .o_pkt_beats (o_pkt_beats),
    .o_abort_cnt (o_abort_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [BEAT_WIDTH-1:0] data;
    logic                  sop;
    logic                  eop;
  } beat_t;

  beat_t                 sq[$];   // pending stimulus beats
  logic [BEAT_WIDTH-1:0] mq[$];   // captured beats of the current packet
  int                    tot;     // beats seen in the current packet (saturating)
  int                    aborts;
  bit                    in_pkt;  // sop seen, eop not yet
  bit                    pres;    // packet being presented
  bit                    acc;     // last edge accepted a beat
  int                    n_chk;
  int                    n_pass;

  task automatic check_eq(input string tag, input logic [PHV_WIDTH-1:0] got,
                          input logic [PHV_WIDTH-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [PHV_WIDTH-1:0] packed_phv();
    logic [PHV_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < mq.size(); i++) r[i*BEAT_WIDTH +: BEAT_WIDTH] = mq[i];
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    tot = 0; aborts = 0; in_pkt = 0; pres = 0; acc = 0;
  endtask

  // Packet-level view of one clock edge.
  task automatic model_edge();
    acc = 0;
    if (pres) begin
      if (i_phv_ready) begin
        pres = 0;
        mq.delete();
        tot = 0;
      end
    end else if (i_data_valid) begin
      acc = 1;
      if (i_sop) begin
        if (in_pkt) aborts = (aborts < 255) ? aborts + 1 : 255;
        mq.delete();
        mq.push_back(i_data);
        tot    = 1;
        in_pkt = 1;
      end else if (in_pkt) begin
        if (mq.size() < BEATS) mq.push_back(i_data);
        if (tot < 65535) tot++;
      end
      if (in_pkt && i_eop) begin
        pres   = 1;
        in_pkt = 0;
      end
    end
  endtask

  task automatic compare_all();
    int pb;
    pb = (tot < BEATS) ? tot : BEATS;
    check_eq("data_ready", o_data_ready, !pres);
    check_eq("phv_valid", o_phv_valid, pres);
    check_eq("phv", o_phv, packed_phv());
    check_eq("pkt_beats", o_pkt_beats, tot);
    check_eq("phv_beats", o_phv_beats, pb);
    check_eq("abort_cnt", o_abort_cnt, aborts);
  endtask

  task automatic step();
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
    compare_all();
  endtask

  task automatic gen_pkt(input int len, input bit with_eop, input bit with_sop);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = {$urandom, $urandom, $urandom, $urandom};
      b.sop  = with_sop && (k == 0);
      b.eop  = with_eop && (k == len - 1);
      sq.push_back(b);
    end
  endtask

  // Feeds the stimulus queue; the source holds each beat until the model
  // says it was taken. During presentation the first 'hold' cycles see
  // i_phv_ready low.
  task automatic run_queue(input int valid_pct, input int ready_pct, input int hold);
    int out_cyc;
    out_cyc = 0;
    while (sq.size() > 0) begin
      i_data_valid = ($urandom_range(99) < valid_pct);
      i_data       = sq[0].data;
      i_sop        = sq[0].sop;
      i_eop        = sq[0].eop;
      if (pres && out_cyc < hold) i_phv_ready = 1'b0;
      else i_phv_ready = ($urandom_range(99) < ready_pct);
      step();
      if (acc) void'(sq.pop_front());
      out_cyc = pres ? out_cyc + 1 : 0;
    end
    i_data_valid = 1'b0;
    i_sop        = 1'b0;
    i_eop        = 1'b0;
    for (int k = 0; k < 4 && pres; k++) begin
      i_phv_ready = 1'b1;
      step();
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    model_reset();
    i_rst_n = 1'b0; i_data_valid = 1'b0; i_data = '0;
    i_sop = 1'b0; i_eop = 1'b0; i_phv_ready = 1'b0;

    #12;
    check_eq("rst_phv", o_phv, '0);
    check_eq("rst_phv_valid", o_phv_valid, 1'b0);
    check_eq("rst_phv_beats", o_phv_beats, '0);
    check_eq("rst_pkt_beats", o_pkt_beats, '0);
    check_eq("rst_abort_cnt", o_abort_cnt, '0);
    check_eq("rst_data_ready", o_data_ready, 1'b1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    compare_all();

    // 3-beat packet, downstream always ready
    gen_pkt(3, 1, 1);
    run_queue(100, 100, 0);
    // single-beat packet
    gen_pkt(1, 1, 1);
    run_queue(100, 100, 0);
    // long packet overflowing the vector
    gen_pkt(20, 1, 1);
    run_queue(100, 100, 0);
    // backpressure with a pending sop behind the presented packet
    gen_pkt(1, 1, 1);
    gen_pkt(2, 1, 1);
    run_queue(100, 100, 5);
    // abort: sop + 2 beats, then a complete 2-beat packet
    gen_pkt(3, 0, 1);
    gen_pkt(2, 1, 1);
    run_queue(100, 100, 0);
    // stray non-sop beats while idle
    gen_pkt(4, 1, 0);
    run_queue(100, 100, 0);

    // reset in the middle of filling
    gen_pkt(6, 1, 1);
    i_phv_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_data_valid = 1'b1;
      i_data = sq[0].data; i_sop = sq[0].sop; i_eop = sq[0].eop;
      step();
      if (acc) void'(sq.pop_front());
    end
    sq.delete();
    i_data_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
    #2 i_rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    compare_all();
    gen_pkt(5, 1, 1);
    run_queue(100, 100, 0);

    // randomized traffic
    for (int p = 0; p < 60; p++) begin
      case ($urandom_range(9))
        7:       gen_pkt($urandom_range(1, 4), 0, 1);
        8:       gen_pkt($urandom_range(1, 3), $urandom_range(1), 0);
        default: gen_pkt($urandom_range(1, 20), 1, 1);
      endcase
    end
    gen_pkt(2, 1, 1);
    run_queue(70, 60, 0);

    // abort counter saturation
    for (int p = 0; p < 260; p++) gen_pkt(1, 0, 1);
    gen_pkt(2, 1, 1);
    run_queue(100, 100, 0);

    // packet beat counter saturation
    gen_pkt(65540, 1, 1);
    run_queue(100, 100, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/phv_assembler.md
# phv_assembler

Gathers a packet's streaming data beats into one PHV_WIDTH-bit header vector (PHV) for the parser's field-extract stage. Captures the first PHV_WIDTH/BEAT_WIDTH beats of each packet. Discards the rest of the packet while still counting its beats. Presents the completed PHV with a valid/ready handshake once the packet's last beat (eop) has been accepted. Sits directly upstream of the field extractors, which index into o_phv.

## Interface
Parameters:
- PHV_WIDTH, 1024, width of the assembled header vector; must be a multiple of BEAT_WIDTH.
- BEAT_WIDTH, 128, width of one input data beat.
- BEATS, PHV_WIDTH/BEAT_WIDTH, number of beats the PHV holds (derived).
- BCNT_WIDTH, $clog2(BEATS+1), width of o_phv_beats (derived).

Ports:
- i_clk  in  1  clock; single clock domain.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_data_valid  in  1  input beat valid.
- i_data  in  BEAT_WIDTH  input beat.
- i_sop  in  1  first beat of packet; qualified by i_data_valid.
- i_eop  in  1  last beat of packet; qualified by i_data_valid.
- o_data_ready  out  1  block accepts a beat this cycle.
- o_phv  out  PHV_WIDTH  assembled header vector.
- o_phv_valid  out  1  o_phv, o_phv_beats and o_pkt_beats are valid.
- i_phv_ready  in  1  downstream consumes the PHV.
- o_phv_beats  out  BCNT_WIDTH  number of beats captured into o_phv (1..BEATS).
- o_pkt_beats  out  16  total beats in the packet; saturates at 16'hFFFF.
- o_abort_cnt  out  8  packets aborted by a new sop before eop; saturates at 8'hFF.

## Operation
- A beat is accepted when i_data_valid && o_data_ready.
- o_data_ready = (state != OUT). It is a combinational decode of registered state.
- Beat k of a packet (k = 0 for the sop beat) is written to o_phv[k*BEAT_WIDTH +: BEAT_WIDTH] when k < BEATS.
  - Beat 0 therefore occupies the least-significant bits.
  - Unwritten slots read 0.
- States:
  - IDLE: waiting for a packet start.
    - Accepted beat with i_sop: clear the buffer, write slot 0, set beat count = 1.
    - Then, if i_eop is also set: go to OUT. Otherwise go to FILL.
    - Accepted beat without i_sop: dropped, no state change, no counter change.
  - FILL: capturing beats.
    - Accepted non-sop beat: write slot[count], increment count.
    - i_eop on that beat: go to OUT.
    - Otherwise, if count reaches BEATS after this beat: go to DRAIN.
  - DRAIN: PHV is full.
    - Accepted non-sop beats only increment o_pkt_beats; data is discarded.
    - i_eop: go to OUT.
  - OUT: o_phv_valid = 1; inputs are stalled.
    - i_phv_ready: go to IDLE and clear the buffer and counters on the next edge.
- Accepted i_sop in FILL or DRAIN (previous packet had no eop):
  - Previous packet is discarded and never presented.
  - o_abort_cnt increments.
  - The beat is handled exactly as an sop beat in IDLE, including sop+eop going to OUT.
- o_phv_beats = min(o_pkt_beats, BEATS).
- o_pkt_beats holds at 16'hFFFF once reached; the packet is still presented normally at eop.
- Reset while in any state: returns to IDLE immediately. Any partial or held PHV is lost.

## Timing
- Reset values:
  - o_phv = 0, o_phv_valid = 0, o_phv_beats = 0, o_pkt_beats = 0, o_abort_cnt = 0, state = IDLE.
  - o_data_ready = 1 during and after reset.
- Latency: o_phv_valid rises on the first edge after the eop beat is accepted.
- o_phv, o_phv_beats and o_pkt_beats are stable while o_phv_valid = 1.
- Handshake:
  - The PHV transfers on the edge where o_phv_valid && i_phv_ready.
  - o_phv_valid falls and o_data_ready rises on that same edge.
  - i_phv_ready may be held high permanently, giving exactly one OUT cycle per packet.
- Throughput: N-beat packet occupies N accept cycles plus at least 1 OUT cycle.
- While in OUT, input beats stay pending. The upstream source must hold i_data, i_sop and i_eop stable until accepted.

## Test plan
- Reset, then a 3-beat packet with beats A/B/C (sop on A, eop on C), i_phv_ready=1:
  - o_phv = {0 x5 slots, C, B, A}, o_phv_beats=3, o_pkt_beats=3.
  - o_phv_valid high for exactly 1 cycle, starting the edge after C.
- Single-beat packet (sop+eop same beat) → OUT next cycle, o_phv_beats=1, upper slots 0.
- 20-beat packet, BEATS=8:
  - Slots hold beats 0..7; o_phv_beats=8, o_pkt_beats=20.
  - o_data_ready stays high through DRAIN.
- Backpressure: i_phv_ready=0 for 5 cycles during OUT.
  - o_data_ready=0 and o_phv stable throughout.
  - A pending sop beat is accepted the cycle after i_phv_ready=1.
- Abort: sop, 2 beats, then a new sop (no eop), then a 2-beat packet.
  - Only the second packet is presented (o_pkt_beats=2); o_abort_cnt=1.
- Stray non-sop beats in IDLE → ignored, no output or counter change.
- Reset asserted mid-FILL → outputs 0 immediately; the next packet assembles cleanly.
